// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
//
// Registered N-channel, W-bit multiplexer with two select modes:
//   manual (mode=0) : channel chosen by sel_in
//   scan   (mode=1) : an internal counter steps through the channels, holding
//                     each one for DWELL enabled cycles, and always restarts at
//                     the first channel when scan is entered.
//
// Optional feature (macro SCAN_MUX_MASK_EN):
//   Adds input ch_mask; a 1 skips that channel in scan mode. If every channel
//   is masked while scanning, the update is suppressed (dout=0, valid=0,
//   err=1) and the counters hold. Without the macro the port is absent and
//   every channel is scanned.
//
// Parameters:
//   WIDTH : data bits per channel (>=1)
//   CH    : number of channels (2..256)
//   SEL_W : select width, derived from CH; do not override
//   DWELL : enabled cycles each channel is held in scan mode (>=1)
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   en       in   cycle enable; low freezes all state (valid/wrap drop to 0)
//   mode     in   0 = manual, 1 = scan
//   sel_in   in   manual channel select
//   din      in   packed channel data, channel k = din[k*WIDTH +: WIDTH]
//   ch_mask  in   (SCAN_MUX_MASK_EN only) per-channel scan skip mask
//   dout     out  registered selected data (1-cycle latency)
//   sel_out  out  channel index that produced dout
//   valid    out  dout/sel_out were updated on the previous edge
//   wrap     out  one-cycle pulse with the first channel after a scan wrap
//   err      out  manual sel_in was out of range (or all channels masked)
//
// Handshake: there is no backpressure. valid is a pure qualifier: when it is
// high, dout/sel_out carry a fresh sample taken on the previous edge; when it
// is low they hold their last value and must not be treated as new data.
// -----------------------------------------------------------------------------
module scan_mux #(
    parameter int WIDTH = 1,
    parameter int CH    = 8,
    parameter int SEL_W = $clog2(CH),
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic [CH*WIDTH-1:0]   din,
`ifdef SCAN_MUX_MASK_EN
    input  logic [CH-1:0]         ch_mask,
`endif
    output logic [WIDTH-1:0]      dout,
    output logic [SEL_W-1:0]      sel_out,
    output logic                  valid,
    output logic                  wrap,
    output logic                  err
);

    // Dwell counter width; one bit is kept even when DWELL=1.
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    // Channel table is padded to the full select range so any sel_in value
    // indexes safely; padded slots read as zero (the out-of-range result).
    localparam int NSLOT = 1 << SEL_W;
    localparam logic [SEL_W:0]    CH_EXT    = (SEL_W+1)'(CH);
    localparam logic [SEL_W-1:0]  LAST_CH   = SEL_W'(CH - 1);
    localparam logic [DW_W-1:0]   LAST_DW   = DW_W'(DWELL - 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] dout_q,    dout_d;
    logic [SEL_W-1:0] sel_q,     sel_d;
    logic             valid_q,   valid_d;
    logic             wrap_q,    wrap_d;
    logic             err_q,     err_d;
    logic [SEL_W-1:0] cnt_q,     cnt_d;      // scan channel counter
    logic [DW_W-1:0]  dwell_q,   dwell_d;    // cycles spent on current channel
    logic             mode_q,    mode_d;     // mode seen on the previous edge
    logic             pend_q,    pend_d;     // counter wrapped; flag next output

    // ---------------------------------------------------------------------
    // Channel table
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] ch_data [NSLOT];

    for (genvar k = 0; k < NSLOT; k++) begin : g_ch
        if (k < CH) begin : g_real
            assign ch_data[k] = din[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch_data[k] = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Scan sequencing helpers
    // ---------------------------------------------------------------------
    logic             entry;       // first enabled update after entering scan
    logic [SEL_W-1:0] start_idx;   // channel scan restarts from
    logic [SEL_W-1:0] scan_chan;   // channel used by this scan update
    logic [SEL_W-1:0] adv_idx;     // channel after scan_chan
    logic             adv_wrap;    // advancing from scan_chan passes CH-1
    logic             all_masked;
    logic             sel_bad;

    assign entry     = mode & ~mode_q;
    assign scan_chan = entry ? start_idx : cnt_q;
    assign sel_bad   = ({1'b0, sel_in} >= CH_EXT);

`ifdef SCAN_MUX_MASK_EN
    logic [SEL_W-1:0] above_idx;
    logic             above_ok;

    assign all_masked = &ch_mask;

    // Lowest unmasked channel. Kept apart from the search below because the
    // search depends on scan_chan, which itself depends on start_idx.
    always_comb begin
        start_idx = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (!ch_mask[k]) begin
                start_idx = SEL_W'(k);
            end
        end
    end

    // Lowest unmasked channel strictly above scan_chan; if there is none the
    // search wraps around to start_idx.
    always_comb begin
        above_idx = '0;
        above_ok  = 1'b0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (!ch_mask[k] && (k > int'(scan_chan))) begin
                above_idx = SEL_W'(k);
                above_ok  = 1'b1;
            end
        end
    end

    assign adv_idx  = above_ok ? above_idx : start_idx;
    assign adv_wrap = ~above_ok;
`else
    assign all_masked = 1'b0;
    assign start_idx  = '0;
    assign adv_wrap   = (scan_chan == LAST_CH);
    assign adv_idx    = adv_wrap ? '0 : scan_chan + 1'b1;
`endif

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    logic [DW_W-1:0] dwell_cur;

    always_comb begin
        dout_d    = dout_q;
        sel_d     = sel_q;
        valid_d   = 1'b0;
        wrap_d    = 1'b0;
        err_d     = err_q;
        cnt_d     = cnt_q;
        dwell_d   = dwell_q;
        mode_d    = mode;
        pend_d    = pend_q;
        dwell_cur = entry ? '0 : dwell_q;

        // Outside scan the sequencer is parked on the start channel with a
        // fresh dwell, so a scan entry that happens while en is low still
        // begins cleanly on the next enabled edge.
        if (!mode) begin
            cnt_d   = start_idx;
            dwell_d = '0;
            pend_d  = 1'b0;
        end

        if (en) begin
            if (!mode) begin
                // Out-of-range selects read a zero padded slot.
                dout_d  = ch_data[sel_in];
                sel_d   = sel_in;
                valid_d = 1'b1;
                err_d   = sel_bad;
            end else if (all_masked) begin
                dout_d  = '0;
                err_d   = 1'b1;
            end else begin
                dout_d  = ch_data[scan_chan];
                sel_d   = scan_chan;
                valid_d = 1'b1;
                err_d   = 1'b0;
                // The wrap pulse accompanies the first channel after the
                // counter wrapped, not the last channel before it.
                wrap_d  = pend_q & ~entry;
                pend_d  = 1'b0;
                if (dwell_cur == LAST_DW) begin
                    dwell_d = '0;
                    cnt_d   = adv_idx;
                    pend_d  = adv_wrap;
                end else begin
                    dwell_d = dwell_cur + 1'b1;
                    cnt_d   = scan_chan;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign dout    = dout_q;
    assign sel_out = sel_q;
    assign valid   = valid_q;
    assign wrap    = wrap_q;
    assign err     = err_q;

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic rst_n  = 1'b1;
    logic en     = 1'b0;

    // DUT A: CH=8, WIDTH=4, DWELL=4, channel k = k+3
    logic        mode_a  = 1'b0;
    logic [2:0]  sel_a   = '0;
    logic [31:0] din_a;
    logic [3:0]  dout_a;
    logic [2:0]  selo_a;
    logic        valid_a, wrap_a, err_a;

    // DUT B: CH=5, WIDTH=4, DWELL=2, channel k = k+9
    logic        mode_b  = 1'b0;
    logic [2:0]  sel_b   = '0;
    logic [19:0] din_b;
    logic [3:0]  dout_b;
    logic [2:0]  selo_b;
    logic        valid_b, wrap_b, err_b;

`ifdef SCAN_MUX_MASK_EN
    logic [7:0]  mask_a  = '0;
    logic [7:0]  mask_b5 = '0;
    logic        mode_c  = 1'b0;
    logic [7:0]  mask_c  = '0;
    logic [3:0]  dout_c;
    logic [2:0]  selo_c;
    logic        valid_c, wrap_c, err_c;
`endif

    scan_mux #(.WIDTH(4), .CH(8), .DWELL(4)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode_a), .sel_in(sel_a),
        .din(din_a),
`ifdef SCAN_MUX_MASK_EN
        .ch_mask(mask_a),
`endif
        .dout(dout_a), .sel_out(selo_a), .valid(valid_a), .wrap(wrap_a), .err(err_a)
    );

    scan_mux #(.WIDTH(4), .CH(5), .DWELL(2)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode_b), .sel_in(sel_b),
        .din(din_b),
`ifdef SCAN_MUX_MASK_EN
        .ch_mask(mask_b5[4:0]),
`endif
        .dout(dout_b), .sel_out(selo_b), .valid(valid_b), .wrap(wrap_b), .err(err_b)
    );

`ifdef SCAN_MUX_MASK_EN
    scan_mux #(.WIDTH(4), .CH(8), .DWELL(1)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode_c), .sel_in(3'd0),
        .din(din_a), .ch_mask(mask_c),
        .dout(dout_c), .sel_out(selo_c), .valid(valid_c), .wrap(wrap_c), .err(err_c)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int d, input int s, input int v,
                         input int w, input int e);
        chk({tag, ".dout"},  32'(dout_a),  d);
        chk({tag, ".sel"},   32'(selo_a),  s);
        chk({tag, ".valid"}, 32'(valid_a), v);
        chk({tag, ".wrap"},  32'(wrap_a),  w);
        chk({tag, ".err"},   32'(err_a),   e);
    endtask

    task automatic chk_b(input string tag, input int d, input int s, input int v,
                         input int e);
        chk({tag, ".dout"},  32'(dout_b),  d);
        chk({tag, ".sel"},   32'(selo_b),  s);
        chk({tag, ".valid"}, 32'(valid_b), v);
        chk({tag, ".err"},   32'(err_b),   e);
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int ch;
        for (int k = 0; k < 8; k++) din_a[k*4 +: 4] = 4'(k + 3);
        for (int k = 0; k < 5; k++) din_b[k*4 +: 4] = 4'(k + 9);

        // Reset at power-up
        #1 rst_n = 1'b0;
        #1;
        chk_a("por", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk_a("post_rel_en0", 0, 0, 0, 0, 0);

        // Manual, A: sel 0..7 -> dout 3..10
        en = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel_a = 3'(s);
            step();
            chk_a($sformatf("man_a%0d", s), s + 3, s, 1, 0, 0);
        end

        // Manual error, B (CH=5)
        sel_b = 3'd6; step(); chk_b("b_sel6", 0, 6, 1, 1);
        sel_b = 3'd2; step(); chk_b("b_sel2", 11, 2, 1, 0);
        sel_b = 3'd4; step(); chk_b("b_sel4", 13, 4, 1, 0);
        sel_b = 3'd5; step(); chk_b("b_sel5", 0, 5, 1, 1);

        // Enable low: valid drops, everything else holds
        en = 1'b0;
        step();
        chk_a("hold_a", 10, 7, 0, 0, 0);
        chk_b("hold_b", 0, 5, 0, 1);

        // Asynchronous reset mid-cycle with dout nonzero
        #2 rst_n = 1'b0;
        #1;
        chk_a("async_rst_a", 0, 0, 0, 0, 0);
        chk_b("async_rst_b", 0, 0, 0, 0);
        #1 rst_n = 1'b1;

        // Scan, A: each channel held 4 cycles, wrap with the 0 after 7
        mode_a = 1'b1;
        en     = 1'b1;
        for (c = 1; c <= 42; c++) begin
            step();
            ch = ((c - 1) / 4) % 8;
            chk_a($sformatf("scan_c%0d", c), ch + 3, ch, 1, (c == 33) ? 1 : 0, 0);
        end

        // Freeze mid-dwell (channel 2, two cycles done); sel_in must be ignored
        en    = 1'b0;
        sel_a = 3'd5;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_a($sformatf("freeze%0d", i), 5, 2, 0, 0, 0);
        end
        en = 1'b1;
        for (c = 43; c <= 50; c++) begin
            step();
            ch = ((c - 1) / 4) % 8;
            chk_a($sformatf("resume_c%0d", c), ch + 3, ch, 1, 0, 0);
        end

        // Reset mid-scan, mode held at 1: restart at channel 0
        #3 rst_n = 1'b0;
        #1;
        chk_a("rst_midscan", 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_a($sformatf("rescan%0d", i), 3, 0, 1, 0, 0);
        end
        step();
        chk_a("rescan_ch1", 4, 1, 1, 0, 0);

        // Leave scan to manual, then re-enter: restart at channel 0
        mode_a = 1'b0;
        sel_a  = 3'd4;
        step();
        chk_a("leave_scan", 7, 4, 1, 0, 0);
        mode_a = 1'b1;
        step();
        chk_a("reenter0", 3, 0, 1, 0, 0);
        step(); step(); step();
        chk_a("reenter3", 3, 0, 1, 0, 0);
        step();
        chk_a("reenter_ch1", 4, 1, 1, 0, 0);

`ifdef SCAN_MUX_MASK_EN
        // Mask, DWELL=1: unmasked 1,3,4,6 -> 1,3,4,6,1,3 with wrap on the 1 after 6
        begin
            int seq [6] = '{1, 3, 4, 6, 1, 3};
            int wr  [6] = '{0, 0, 0, 0, 1, 0};
            mask_c = 8'b1010_0101;
            mode_c = 1'b1;
            for (int i = 0; i < 6; i++) begin
                step();
                chk($sformatf("mask_sel%0d", i),  32'(selo_c), seq[i]);
                chk($sformatf("mask_dout%0d", i), 32'(dout_c), seq[i] + 3);
                chk($sformatf("mask_wrap%0d", i), 32'(wrap_c), wr[i]);
            end
            mask_c = 8'hFF;
            step();
            chk("mask_all_valid", 32'(valid_c), 0);
            chk("mask_all_err",   32'(err_c),   1);
            chk("mask_all_dout",  32'(dout_c),  0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with two select modes.
  - Manual mode: the select comes from a port.
  - Scan mode: an internal counter steps through every channel, holding each for a programmable number of enabled cycles.
- Successor to the fixed 8:1 single-bit gate-level mux; used to time-multiplex lab sensor/switch channels onto one display or output bus.

Parameters:
- WIDTH, 1, data bits per channel (>=1).
- CH, 8, number of input channels (2..256).
- SEL_W, $clog2(CH), select width; derived, do not override.
- DWELL, 4, enabled cycles each channel is held in scan mode (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  cycle enable; when low, all state holds.
- mode  input  1  0 = manual select, 1 = scan.
- sel_in  input  SEL_W  manual channel select.
- din  input  CH*WIDTH  packed channel data; channel k = din[k*WIDTH +: WIDTH].
- dout  output  WIDTH  registered selected data.
- sel_out  output  SEL_W  channel index that produced the current dout.
- valid  output  1  dout/sel_out updated on the previous edge.
- wrap  output  1  one-cycle pulse when scan wraps from the last channel to 0.
- err  output  1  registered flag: manual sel_in >= CH on the last update.

Behaviour:
- Reset (rst_n low, asynchronous): dout=0, sel_out=0, valid=0, wrap=0, err=0, scan channel counter=0, dwell counter=0, mode_q=0.
- Latency: 1 clock. On an edge with en=1, dout <= din[chan], sel_out <= chan, valid <= 1.
- On an edge with en=0: valid <= 0, wrap <= 0. dout, sel_out, err and all counters hold.
- Manual mode (mode=1'b0), chan = sel_in:
  - If sel_in >= CH (possible only when CH is not a power of two): dout <= 0, sel_out <= sel_in, err <= 1.
  - Otherwise err <= 0.
- Scan mode (mode=1'b1), chan = scan counter; err <= 0.
  - Dwell counter increments on each en cycle.
  - When dwell == DWELL-1: dwell <= 0 and the channel advances.
  - If the channel is CH-1, it returns to 0 and wrap <= 1 for exactly that cycle; otherwise wrap <= 0.
  - DWELL=1: advance every enabled cycle.
- Mode entry: mode_q registers mode on every edge, regardless of en.
  - A transition 0->1 (mode=1, mode_q=0) on an enabled edge forces chan=0 for that update; next state is dwell=1 (or channel 1 if DWELL=1).
  - Scan always restarts at channel 0.
  - Leaving scan clears the dwell counter; the channel counter is reset to 0 on the next entry.
- sel_in changes mid-dwell in scan mode are ignored.
- din is sampled only on enabled edges; no combinational path from din to dout.
- Reset asserted mid-scan: immediate return to the reset values above. The first enabled edge after release outputs channel 0 (scan) or sel_in (manual).

Optional Feature:
- Macro: SCAN_MUX_MASK_EN.
- Defined:
  - Adds input ch_mask [CH-1:0]; a 1 means the channel is skipped in scan mode.
  - On advance, the counter moves to the next unmasked index above the current one, cyclically. wrap pulses when the search passes index CH-1.
  - On scan entry, the start channel is the lowest unmasked index.
  - If ch_mask is all ones: dout <= 0, valid <= 0, err <= 1, and counters hold.
  - Manual mode ignores ch_mask.
- Undefined: port absent; all channels scanned.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle with dout nonzero -> dout=0, sel_out=0, valid=0, wrap=0, err=0 immediately, without waiting for a clock edge.
- Manual, CH=8, WIDTH=4, din channel k = k+3, en=1, sel_in stepping 0..7 -> dout one cycle later = 3..10, sel_out matches, valid=1, err=0.
- Scan, CH=8, DWELL=4, en=1 for 40 cycles -> each channel held 4 cycles in order 0..7; wrap pulses once at the 0 after 7 (cycle 33 after entry); then repeats.
- Enable gating in scan: drop en for 5 cycles mid-dwell -> dout, sel_out and dwell frozen, valid=0. On resume the remaining dwell cycles complete with no skipped channel.
- Manual error, CH=5: sel_in=6 -> dout=0, err=1, sel_out=6. Then sel_in=2 -> err=0, dout=din[2].
- Mask (SCAN_MUX_MASK_EN): CH=8, DWELL=1, ch_mask=8'b1010_0101 -> sequence 1,3,4,6,1,... with wrap on each 6->1. ch_mask=8'hFF -> valid=0, err=1.
